// File: rtl/commit_queue.sv
// In-order commit buffer: allocates entries at issue, captures CDB results by RS tag,
// and retires completed entries from the head as a registered rob_id/rob_data write-back.
module commit_queue #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              issue_valid_i,
  input  logic [TAG_W-1:0]  issue_tag_i,
  input  logic              issue_nodest_i,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_data_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o,
  output logic [TAG_W-1:0]  rob_id_o,
  output logic [DATA_W-1:0] rob_data_o
);

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0]             done_q, done_d;
  logic [DEPTH-1:0]             nodest_q, nodest_d;
  logic [DEPTH-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic [PTR_W-1:0]             head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [TAG_W-1:0]             rob_id_q, rob_id_d;
  logic [DATA_W-1:0]            rob_data_q, rob_data_d;

  logic issue_ok, cdb_act, commit;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign rob_id_o   = rob_id_q;
  assign rob_data_o = rob_data_q;

  // full is taken from pre-commit occupancy, so a same-cycle commit never admits an issue
  assign issue_ok = issue_valid_i && (issue_tag_i != '0) && !full_o;
  assign cdb_act  = cdb_valid_i && (cdb_tag_i != '0);
  assign commit   = valid_q[head_q] && done_q[head_q];

  always_comb begin
    valid_d    = valid_q;
    done_d     = done_q;
    nodest_d   = nodest_q;
    tag_d      = tag_q;
    data_d     = data_q;
    head_d     = head_q + PTR_W'(commit);
    tail_d     = tail_q + PTR_W'(issue_ok);
    count_d    = count_q + CNT_W'(issue_ok) - CNT_W'(commit);
    rob_id_d   = '0;
    rob_data_d = '0;
    if (commit && !nodest_q[head_q]) begin
      rob_id_d   = tag_q[head_q];
      rob_data_d = data_q[head_q];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (commit && head_q == PTR_W'(i))
        valid_d[i] = 1'b0;
      // matching uses current state only, so an entry issued this cycle cannot be hit
      if (cdb_act && valid_q[i] && !done_q[i] && tag_q[i] == cdb_tag_i) begin
        done_d[i] = 1'b1;
        data_d[i] = cdb_data_i;
      end
      if (issue_ok && tail_q == PTR_W'(i)) begin
        valid_d[i]  = 1'b1;
        done_d[i]   = 1'b0;
        nodest_d[i] = issue_nodest_i;
        tag_d[i]    = issue_tag_i;
        data_d[i]   = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= '0;
      done_q     <= '0;
      nodest_q   <= '0;
      tag_q      <= '0;
      data_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rob_id_q   <= '0;
      rob_data_q <= '0;
    end else begin
      valid_q    <= valid_d;
      done_q     <= done_d;
      nodest_q   <= nodest_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rob_id_q   <= rob_id_d;
      rob_data_q <= rob_data_d;
    end
  end

endmodule

// File: tb/tb_commit_queue.sv
// Bench for commit_queue: directed scenarios then random traffic, compared each cycle
// against a queue-based model of program-order entries.
module tb_commit_queue;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_valid = 1'b0;
  logic [3:0]  issue_tag = '0;
  logic        issue_nodest = 1'b0;
  logic        cdb_valid = 1'b0;
  logic [3:0]  cdb_tag = '0;
  logic [63:0] cdb_data = '0;
  logic        full, empty;
  logic [3:0]  count;
  logic [3:0]  rob_id;
  logic [63:0] rob_data;

  int total = 0;
  int bad = 0;

  commit_queue #(.DEPTH(DEPTH), .TAG_W(4), .DATA_W(64)) dut (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(issue_valid), .issue_tag_i(issue_tag), .issue_nodest_i(issue_nodest),
    .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_data_i(cdb_data),
    .full_o(full), .empty_o(empty), .count_o(count),
    .rob_id_o(rob_id), .rob_data_o(rob_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    bit          nodest;
    bit          done;
    logic [63:0] data;
  } ent_t;

  ent_t        mq[$];
  int          exp_id = 0;
  logic [63:0] exp_data = '0;

  task automatic check(string name, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic bit pending(int t);
    for (int k = 0; k < mq.size(); k++)
      if (!mq[k].done && mq[k].tag == t) return 1'b1;
    return 1'b0;
  endfunction

  // one clock: drive inputs, advance the model, compare outputs after the edge
  task automatic step(bit iv, int itag, bit inod, bit cv, int ctag, logic [63:0] cd, bit r);
    bit commit, was_full;
    @(negedge clk);
    rst = r; issue_valid = iv; issue_tag = itag[3:0]; issue_nodest = inod;
    cdb_valid = cv; cdb_tag = ctag[3:0]; cdb_data = cd;
    @(posedge clk);
    if (r) begin
      mq.delete();
      exp_id = 0; exp_data = '0;
    end else begin
      commit   = (mq.size() > 0) && mq[0].done;
      was_full = (mq.size() == DEPTH);
      exp_id   = 0; exp_data = '0;
      if (commit && !mq[0].nodest) begin
        exp_id = mq[0].tag; exp_data = mq[0].data;
      end
      if (cv && ctag != 0)
        for (int k = 0; k < mq.size(); k++)
          if (!mq[k].done && mq[k].tag == ctag) begin
            mq[k].done = 1'b1; mq[k].data = cd;
            break;
          end
      if (commit) void'(mq.pop_front());
      if (iv && itag != 0 && !was_full)
        mq.push_back('{tag: itag, nodest: inod, done: 1'b0, data: 64'd0});
    end
    #1;
    check("count", 64'(count), 64'(mq.size()));
    check("full", 64'(full), 64'(mq.size() == DEPTH));
    check("empty", 64'(empty), 64'(mq.size() == 0));
    check("rob_id", 64'(rob_id), 64'(exp_id));
    check("rob_data", rob_data, exp_data);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 64'd0, 0);
  endtask

  task automatic iss(int t, bit nd);
    step(1, t, nd, 0, 0, 64'd0, 0);
  endtask

  task automatic cdb(int t, logic [63:0] d);
    step(0, 0, 0, 1, t, d, 0);
  endtask

  initial begin
    int ct, it;
    bit cv, iv;
    // reset and idle
    step(0, 0, 0, 0, 0, 64'd0, 1);
    idle(5);
    // out-of-order completion, in-order commit
    iss(1, 0); iss(4, 0); iss(6, 0);
    cdb(6, 64'h66); cdb(4, 64'h44); cdb(1, 64'h11);
    idle(4);
    // nodest entry retires silently
    iss(9, 1); iss(2, 0);
    cdb(2, 64'h22); cdb(9, 64'h0);
    idle(3);
    // fill, drop when full, drain, wrap
    for (int t = 1; t <= 8; t++) iss(t, 0);
    iss(9, 0);
    step(1, 10, 0, 1, 8, 64'h808, 0);
    for (int t = 7; t >= 1; t--) cdb(t, 64'(t * 16 + 1));
    idle(2);
    step(1, 10, 0, 1, 0, 64'hdead, 0);
    iss(1, 0); iss(2, 0);
    cdb(2, 64'h2b); cdb(10, 64'hab); cdb(1, 64'h1b);
    idle(4);
    // tag reuse after completion
    iss(1, 0); cdb(1, 64'hA); iss(1, 0); cdb(1, 64'hB);
    idle(3);
    // same-tag issue+CDB in one cycle: only the older entry is hit
    iss(5, 0);
    step(1, 5, 0, 1, 5, 64'h55, 0);
    cdb(5, 64'h56);
    idle(3);
    // reset with pending work
    iss(3, 0); iss(5, 0); iss(7, 0); iss(8, 0);
    cdb(5, 64'h5); cdb(8, 64'h8);
    step(0, 0, 0, 0, 0, 64'd0, 1);
    cdb(5, 64'h5); cdb(8, 64'h8); cdb(3, 64'h3);
    idle(3);
    // random traffic
    for (int n = 0; n < 1500; n++) begin
      cv = ($urandom_range(0, 1) == 1);
      ct = $urandom_range(0, 15);
      if (cv && mq.size() > 0 && $urandom_range(0, 4) != 0)
        ct = mq[$urandom_range(0, mq.size() - 1)].tag;
      iv = ($urandom_range(0, 9) < 6);
      it = $urandom_range(0, 10);
      if (pending(it) && !(cv && ct == it)) it = 0;
      step(iv, it, ($urandom_range(0, 3) == 0), cv, ct,
           {$urandom(), $urandom()}, ($urandom_range(0, 299) == 0));
    end
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end
endmodule
